// File: rtl/riscv_v_elem_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------------------+
// | riscv_v_elem_seq: splits a vector instruction into LANE_W-bit beats with masks.      |
// | Optional RISCV_V_VSTART_RESUME_EN reports the restart element on flush. Rev 1.0      |
// +--------------------------------------------------------------------------------------+
module riscv_v_elem_seq #(
    parameter  int VLEN   = 256,
    parameter  int LANE_W = 64,
    localparam int VL_W   = $clog2(VLEN/8) + 1,
    localparam int BEAT_W = $clog2(VLEN/LANE_W),
    localparam int MSK_W  = LANE_W/8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_pipe,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_vsew,
    input  logic [VL_W-1:0]   req_vl,
    input  logic [VL_W-1:0]   req_vstart,
    input  logic              req_is_reduct,
    output logic              uop_valid,
    input  logic              uop_ready,
    output logic [BEAT_W-1:0] uop_idx,
    output logic [VL_W-1:0]   uop_elem_base,
    output logic [MSK_W-1:0]  uop_elem_mask,
    output logic              uop_first,
    output logic              uop_last,
    output logic              uop_red,
    output logic              busy,
    output logic              done,
    output logic              done_err,
    output logic [VL_W-1:0]   vstart_upd,
    output logic              vstart_upd_valid
);

    localparam int EPB_SH = $clog2(MSK_W);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RED   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          state_q, state_nxt;
    logic [1:0]      sew_q;
    logic [VL_W-1:0] vl_q, vstart_q, base_q;
    logic            red_q, first_q, err_q;

    logic [VL_W-1:0] vlmax_req, vl_eff_req, epb_req, base_init, epb;
    logic [VL_W:0]   next_base, elem;
    logic            last_beat, accept, fire;

    always_comb begin
        vlmax_req  = VL_W'(VLEN/8) >> req_vsew[1:0];
        vl_eff_req = (req_vl < vlmax_req) ? req_vl : vlmax_req;
        epb_req    = VL_W'(MSK_W) >> req_vsew[1:0];
        base_init  = req_vstart & ~(epb_req - VL_W'(1));
        epb        = VL_W'(MSK_W) >> sew_q;
        next_base  = {1'b0, base_q} + {1'b0, epb};
        last_beat  = next_base >= {1'b0, vl_q};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_nxt;
    end

    // clear_pipe masks every handshake and the done pulse in the cycle it is seen.
    always_comb begin
        state_nxt     = state_q;
        req_ready     = 1'b0;
        uop_valid     = 1'b0;
        uop_first     = 1'b0;
        uop_last      = 1'b0;
        uop_red       = 1'b0;
        uop_idx       = '0;
        uop_elem_base = '0;
        uop_elem_mask = '0;
        done          = 1'b0;
        done_err      = 1'b0;
        elem          = '0;
        case (state_q)
            S_IDLE: begin
                req_ready = !clear_pipe;
                if (req_valid) begin
                    if (req_vsew[2] || (req_vstart >= vl_eff_req)) state_nxt = S_DONE;
                    else                                            state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                uop_valid     = !clear_pipe;
                uop_first     = first_q;
                uop_last      = last_beat;
                uop_idx       = BEAT_W'(base_q >> (EPB_SH - int'(sew_q)));
                uop_elem_base = base_q;
                for (int i = 0; i < MSK_W; i++) begin
                    elem = {1'b0, base_q} + (VL_W+1)'(i);
                    uop_elem_mask[i] = (VL_W'(i) < epb) && (elem >= {1'b0, vstart_q})
                                       && (elem < {1'b0, vl_q});
                end
                if (uop_ready && last_beat) state_nxt = red_q ? S_RED : S_DONE;
            end
            S_RED: begin
                uop_valid     = !clear_pipe;
                uop_red       = 1'b1;
                uop_last      = 1'b1;
                uop_idx       = BEAT_W'(base_q >> (EPB_SH - int'(sew_q)));
                uop_elem_base = base_q;
                if (uop_ready) state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = !clear_pipe;
                done_err  = err_q && !clear_pipe;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        if (clear_pipe) state_nxt = S_IDLE;
    end

    assign busy   = (state_q != S_IDLE);
    assign accept = req_valid && req_ready;
    assign fire   = uop_valid && uop_ready && (state_q == S_ISSUE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sew_q    <= '0;
            vl_q     <= '0;
            vstart_q <= '0;
            base_q   <= '0;
            red_q    <= 1'b0;
            first_q  <= 1'b0;
            err_q    <= 1'b0;
        end else if (accept) begin
            sew_q    <= req_vsew[1:0];
            vl_q     <= vl_eff_req;
            vstart_q <= req_vstart;
            base_q   <= base_init;
            red_q    <= req_is_reduct;
            first_q  <= 1'b1;
            err_q    <= req_vsew[2];
        end else if (fire) begin
            first_q <= 1'b0;
            if (!last_beat) base_q <= next_base[VL_W-1:0];
        end
    end

`ifdef RISCV_V_VSTART_RESUME_EN
    logic [VL_W-1:0] upd_q;
    logic            upd_vld_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            upd_q     <= '0;
            upd_vld_q <= 1'b0;
        end else begin
            upd_vld_q <= clear_pipe && ((state_q == S_ISSUE) || (state_q == S_RED));
            if (clear_pipe && (state_q == S_ISSUE))
                upd_q <= (vstart_q > base_q) ? vstart_q : base_q;
            else if (clear_pipe && (state_q == S_RED))
                upd_q <= vl_q;
        end
    end

    assign vstart_upd       = upd_q;
    assign vstart_upd_valid = upd_vld_q;
`else
    assign vstart_upd       = '0;
    assign vstart_upd_valid = 1'b0;
`endif

endmodule
`default_nettype wire
